// File: rtl/fft_bitrev_reorder_if.sv
// Streaming bus for the FFT bit-reversal reorder stage: ce/valid input side and registered output side.
// last_o is present only when FFT_REORDER_LAST_EN is defined.
interface fft_bitrev_reorder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             ce;
    logic             valid_i;
    logic [WIDTH-1:0] a;
    logic             valid_o;
    logic [WIDTH-1:0] x;
`ifdef FFT_REORDER_LAST_EN
    logic             last_o;

    modport master (output ce, valid_i, a, input valid_o, x, last_o);
    modport slave  (input ce, valid_i, a, output valid_o, x, last_o);
`else
    modport master (output ce, valid_i, a, input valid_o, x);
    modport slave  (input ce, valid_i, a, output valid_o, x);
`endif
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer after the last FFT stage; writes at bitrev(idx), reads sequentially.
// Optional FFT_REORDER_LAST_EN adds a registered last_o marking the final sample of each output frame.
module fft_bitrev_reorder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LOG2N = 4
) (
    input logic                  CLK,
    input logic                  RST,
    fft_bitrev_reorder_if.slave  bus
);
    localparam int unsigned      N        = 1 << LOG2N;
    localparam int unsigned      AW       = LOG2N + 1;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = v[int'(LOG2N) - 1 - i];
        end
        return r;
    endfunction

    // Bank select is the address MSB; contents are intentionally not reset.
    logic [WIDTH-1:0] mem_q [2*N];

    logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
    logic             wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
    logic             rd_bank_q, rd_bank_d;
    logic             rd_active_q, rd_active_d;
    logic             valid_o_q, valid_o_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             wr_en_c;
    logic             frame_done_c;
`ifdef FFT_REORDER_LAST_EN
    logic             last_q, last_d;
`endif

    assign wr_en_c      = bus.ce && bus.valid_i;
    assign frame_done_c = wr_en_c && (wr_idx_q == LAST_IDX);

    always_ff @(posedge CLK) begin
        if (wr_en_c) begin
            mem_q[AW'({wr_bank_q, bitrev(wr_idx_q)})] <= bus.a;
        end
    end

    always_comb begin
        wr_idx_d    = wr_idx_q;
        wr_bank_d   = wr_bank_q;
        rd_idx_d    = rd_idx_q;
        rd_bank_d   = rd_bank_q;
        rd_active_d = rd_active_q;
        valid_o_d   = valid_o_q;
        x_d         = x_q;
`ifdef FFT_REORDER_LAST_EN
        last_d      = last_q;
`endif
        if (wr_en_c) begin
            wr_idx_d = wr_idx_q + LOG2N'(1);
            if (frame_done_c) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
        if (bus.ce) begin
            if (rd_active_q) begin
                x_d       = mem_q[AW'({rd_bank_q, rd_idx_q})];
                valid_o_d = 1'b1;
                rd_idx_d  = rd_idx_q + LOG2N'(1);
`ifdef FFT_REORDER_LAST_EN
                last_d    = (rd_idx_q == LAST_IDX);
`endif
                if (rd_idx_q == LAST_IDX) begin
                    rd_active_d = 1'b0;
                end
            end else begin
                valid_o_d = 1'b0;
`ifdef FFT_REORDER_LAST_EN
                last_d    = 1'b0;
`endif
            end
            // A completing frame re-arms the reader, overriding the end of the previous readout.
            if (frame_done_c) begin
                rd_bank_d   = wr_bank_q;
                rd_idx_d    = '0;
                rd_active_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_idx_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_active_q <= 1'b0;
            valid_o_q   <= 1'b0;
            x_q         <= '0;
`ifdef FFT_REORDER_LAST_EN
            last_q      <= 1'b0;
`endif
        end else begin
            wr_idx_q    <= wr_idx_d;
            wr_bank_q   <= wr_bank_d;
            rd_idx_q    <= rd_idx_d;
            rd_bank_q   <= rd_bank_d;
            rd_active_q <= rd_active_d;
            valid_o_q   <= valid_o_d;
            x_q         <= x_d;
`ifdef FFT_REORDER_LAST_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.valid_o = valid_o_q;
    assign bus.x       = x_q;
`ifdef FFT_REORDER_LAST_EN
    assign bus.last_o  = last_q;
`endif
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed self-checking bench for fft_bitrev_reorder with N=16 and WIDTH=16.
module tb_fft_bitrev_reorder;
    localparam int unsigned WIDTH = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    fft_bitrev_reorder_if #(.WIDTH(WIDTH)) bus ();
    fft_bitrev_reorder #(.WIDTH(WIDTH), .LOG2N(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int checks = 0;
    int errors = 0;
    int unsigned br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    task automatic step(input logic c, input logic v, input int unsigned d);
        bus.ce      = c;
        bus.valid_i = v;
        bus.a       = WIDTH'(d);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        bus.ce = 1'b0; bus.valid_i = 1'b0; bus.a = '0;
        #12;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus.valid_o); end
        checks++; if (bus.x !== 16'd0) begin errors++; $display("FAIL reset_x got %0d expected 0", bus.x); end
`ifdef FFT_REORDER_LAST_EN
        checks++; if (bus.last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b expected 0", bus.last_o); end
`endif
        @(posedge CLK); #1;
        RST = 1'b1;
    endtask

    task automatic test_single_frame;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, i);
            checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL single_idle_valid i=%0d got %b expected 0", i, bus.valid_o); end
        end
        for (int j = 0; j < 16; j++) begin
            step(1'b1, 1'b0, 0);
            checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL single_valid j=%0d got %b expected 1", j, bus.valid_o); end
            checks++; if (bus.x !== 16'(br[j])) begin errors++; $display("FAIL single_x j=%0d got %0d expected %0d", j, bus.x, br[j]); end
        end
        step(1'b1, 1'b0, 0);
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL single_end_valid got %b expected 0", bus.valid_o); end
        checks++; if (bus.x !== 16'd15) begin errors++; $display("FAIL single_end_x_hold got %0d expected 15", bus.x); end
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t < 49; t++) begin
            logic        exp_v;
            int unsigned exp_x;
            if (t < 32) step(1'b1, 1'b1, t);
            else        step(1'b1, 1'b0, 0);
            exp_v = (t >= 16) && (t < 48);
            exp_x = (t < 32) ? br[(t - 16) & 15] : 16 + br[(t - 32) & 15];
            checks++; if (bus.valid_o !== exp_v) begin errors++; $display("FAIL b2b_valid t=%0d got %b expected %b", t, bus.valid_o, exp_v); end
            if (exp_v) begin
                checks++; if (bus.x !== 16'(exp_x)) begin errors++; $display("FAIL b2b_x t=%0d got %0d expected %0d", t, bus.x, exp_x); end
            end
`ifdef FFT_REORDER_LAST_EN
            begin
                logic exp_l;
                exp_l = exp_v && (((t - 16) % 16) == 15);
                checks++; if (bus.last_o !== exp_l) begin errors++; $display("FAIL b2b_last t=%0d got %b expected %b", t, bus.last_o, exp_l); end
            end
`endif
        end
    endtask

    task automatic test_input_gaps;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, i);
            checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL gaps_idle_valid i=%0d got %b expected 0", i, bus.valid_o); end
            if (i < 15) begin
                step(1'b1, 1'b0, 16'hdead);
                checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL gaps_gap_valid i=%0d got %b expected 0", i, bus.valid_o); end
            end
        end
        for (int j = 0; j < 16; j++) begin
            step(1'b1, 1'b0, 0);
            checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL gaps_valid j=%0d got %b expected 1", j, bus.valid_o); end
            checks++; if (bus.x !== 16'(br[j])) begin errors++; $display("FAIL gaps_x j=%0d got %0d expected %0d", j, bus.x, br[j]); end
        end
        step(1'b1, 1'b0, 0);
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL gaps_end_valid got %b expected 0", bus.valid_o); end
    endtask

    task automatic test_ce_stall;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, i);
        for (int j = 0; j < 6; j++) begin
            step(1'b1, 1'b0, 0);
            checks++; if (bus.x !== 16'(br[j]) || bus.valid_o !== 1'b1) begin errors++; $display("FAIL stall_pre j=%0d got x=%0d v=%b expected x=%0d v=1", j, bus.x, bus.valid_o, br[j]); end
        end
        // valid_i high with ce low must not write anything
        for (int s = 0; s < 5; s++) begin
            step(1'b0, 1'b1, 999);
            checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid s=%0d got %b expected 1", s, bus.valid_o); end
            checks++; if (bus.x !== 16'd10) begin errors++; $display("FAIL stall_x s=%0d got %0d expected 10", s, bus.x); end
        end
        for (int j = 6; j < 16; j++) begin
            step(1'b1, 1'b0, 0);
            checks++; if (bus.x !== 16'(br[j]) || bus.valid_o !== 1'b1) begin errors++; $display("FAIL stall_post j=%0d got x=%0d v=%b expected x=%0d v=1", j, bus.x, bus.valid_o, br[j]); end
        end
        step(1'b1, 1'b0, 0);
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL stall_end_valid got %b expected 0", bus.valid_o); end
    endtask

    task automatic test_reset_mid_frame;
        // full frame 50..65, then partial 0..7 overlapping its readout
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b1, (i < 16) ? 50 + i : i - 16);
            if (i >= 16) begin
                checks++; if (bus.x !== 16'(50 + br[i - 16])) begin errors++; $display("FAIL rstmid_pre_x i=%0d got %0d expected %0d", i, bus.x, 50 + br[i - 16]); end
            end
        end
        bus.valid_i = 1'b0;
        RST = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b expected 0", bus.valid_o); end
        checks++; if (bus.x !== 16'd0) begin errors++; $display("FAIL rstmid_x got %0d expected 0", bus.x); end
        for (int c = 0; c < 2; c++) begin
            @(posedge CLK); #1;
            checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_hold_valid c=%0d got %b expected 0", c, bus.valid_o); end
        end
        RST = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 100 + i);
            checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_post_valid i=%0d got %b expected 0", i, bus.valid_o); end
        end
        for (int j = 0; j < 16; j++) begin
            step(1'b1, 1'b0, 0);
            checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_out_valid j=%0d got %b expected 1", j, bus.valid_o); end
            checks++; if (bus.x !== 16'(100 + br[j])) begin errors++; $display("FAIL rstmid_out_x j=%0d got %0d expected %0d", j, bus.x, 100 + br[j]); end
        end
        step(1'b1, 1'b0, 0);
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_end_valid got %b expected 0", bus.valid_o); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_input_gaps();
        test_ce_stall();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
Output reorder stage placed directly after the last FFT butterfly/delay stage. It accepts one natural-index sample per ce-qualified cycle. It writes each sample into a ping-pong buffer at the bit-reversed address. When a frame is complete it streams that frame out in sequential address order, so the downstream logic sees bit-reversal-corrected order. It uses the same ce/valid streaming convention as the FFT pipeline stages.

Parameters:
WIDTH, 16, sample word width in bits (packed re/im allowed, treated as opaque).
LOG2N, 4, log2 of frame length N; N = 2**LOG2N; legal range 2..10.

Ports:
CLK  input  1  clock, all state updates on rising edge.
RST  input  1  asynchronous active-low reset.
ce  input  1  clock enable; when low, all state (counters, bank flags, outputs) holds.
valid_i  input  1  input sample qualifier, sampled only when ce=1.
a  input  WIDTH  input sample, natural order.
valid_o  output  1  output sample qualifier.
x  output  WIDTH  output sample, reordered.
last_o  output  1  present only with FFT_REORDER_LAST_EN; marks final sample of an output frame.

Behaviour:
- Storage: two banks, each N x WIDTH (bank 0/1). Memory contents are not reset. All control and output registers are reset.
- Reset values: valid_o=0, x=0, last_o=0, wr_idx=0, wr_bank=0, rd_active=0, rd_idx=0, rd_bank=0.
- Write side, on each edge with ce=1 and valid_i=1:
  - Store a at bank[wr_bank][bitrev(wr_idx)], where bitrev mirrors the LOG2N bits.
  - wr_idx increments modulo N.
  - On the write with wr_idx=N-1: wr_idx wraps to 0, wr_bank toggles, and a frame-done pulse arms the read side (rd_bank <= old wr_bank, rd_idx <= 0, rd_active <= 1) on that same edge.
- valid_i=0 with ce=1: no write, counters hold. Gaps inside a frame are allowed.
- Read side, on each edge with ce=1 and rd_active=1:
  - x <= bank[rd_bank][rd_idx], valid_o <= 1, rd_idx increments.
  - After rd_idx=N-1 is read, rd_active <= 0.
- Read side, on an edge with ce=1 and rd_active=0: valid_o <= 0; x holds its last value.
- Latency: the frame's final input write is at edge k. The first output is registered at edge k+1. Output is N consecutive ce-cycles with valid_o=1, ending at edge k+N. Output is gap-free regardless of input gaps.
- Simultaneous events:
  - A new frame can complete at the earliest at edge k+N, on the same edge the previous read consumes rd_idx=N-1.
  - In that case the re-arm takes priority: rd_active stays 1, rd_idx restarts at 0, and the next bank is read from edge k+N+1.
  - valid_o stays high across frames with no bubble.
- Write and read always target opposite banks. Read-during-write on the same bank cannot occur, and no overflow condition exists.
- Reset mid-frame: the partial input frame and any in-progress output frame are discarded. The first post-reset valid_i starts a new frame at wr_idx=0 in bank 0.
- ce low mid-frame or mid-readout: everything freezes and resumes exactly where it stopped. valid_o and x keep their current values while ce is low.

Optional Feature:
FFT_REORDER_LAST_EN
- Defined: adds the last_o port. last_o is registered alongside valid_o; it is 1 exactly when the output sample read at rd_idx=N-1 is presented, and 0 otherwise (reset 0).
- Undefined: the last_o port and its logic are absent; all other behaviour is identical.

Test Plan:
- N=16: drive a=0..15 on 16 consecutive cycles with ce=1 and valid_i=1. Required: x=0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, with valid_o=1 on the 16 cycles starting 1 cycle after the a=15 write.
- Back-to-back frames: drive a=0..31 continuously. Required: 32 contiguous valid_o cycles. Frame 2 output is 16,24,20,28,… and the first frame-2 sample follows the last frame-1 sample with no bubble.
- Input gaps: frame 0..15 with valid_i low every other cycle. Required: the same output sequence as the first test, gap-free, starting 1 cycle after the a=15 write.
- ce stall: drop ce for 5 cycles during the 6th output sample. Required: x and valid_o hold during the stall, and the sequence resumes with no lost or duplicated samples.
- Reset mid-frame: write a=0..7, assert RST low for 2 cycles, then write a=100..115. Required: valid_o=0 during and after reset. Output is 100,108,104,112,…,115 in bit-reversed order.
- With FFT_REORDER_LAST_EN: repeat the back-to-back frames test. Required: last_o=1 only with x=15 and with x=31.
